// File: rtl/hk_arb_pkg.sv
// Shared types and defaults for the housekeeping bus arbiter.
package hk_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

  // One captured master request.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        wr;
  } hk_req_t;

  localparam int unsigned TmoDefault = 255;

endpackage

// File: rtl/hk_arb_req_latch.sv
// Per-master request capture: pending bit, request register, same-cycle bypass and drop flag.
module hk_arb_req_latch
  import hk_arb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wen_i,
  input  logic        ren_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_i,
  input  logic        clr_i,
  output logic        valid_o,
  output hk_req_t     req_o,
  output logic        drop_o
);

  logic    stb;
  hk_req_t stb_req;
  logic    pend_q;
  hk_req_t req_q;
  logic    drop_q;

  assign stb     = wen_i | ren_i;
  assign stb_req = '{addr: addr_i, wdata: wdata_i, sel: sel_i, wr: wen_i};

  // Capture a strobe when free; the clear from the ack cycle frees the slot for a same-cycle strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      req_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (clr_i) begin
        pend_q <= 1'b0;
      end
      if (stb) begin
        if (pend_q && !clr_i) begin
          drop_q <= 1'b1;
        end else begin
          req_q  <= stb_req;
          pend_q <= 1'b1;
        end
      end
    end
  end

  // A strobe this cycle is eligible immediately when nothing is held.
  assign valid_o = pend_q | stb;
  assign req_o   = pend_q ? req_q : stb_req;
  assign drop_o  = drop_q;

endmodule

// File: rtl/hk_bus_arbiter.sv
// Two-master round-robin arbiter for the housekeeping slave, one transaction in flight, with timeout.
module hk_bus_arbiter
  import hk_arb_pkg::*;
#(
  parameter int unsigned      TMO_W = 8,
  parameter logic [TMO_W-1:0] TMO   = TMO_W'(TmoDefault)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sel,
  input  logic        m0_wen,
  input  logic        m0_ren,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sel,
  input  logic        m1_wen,
  input  logic        m1_ren,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_sel,
  output logic        s_wen,
  output logic        s_ren,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  input  logic        s_err,
  output logic [1:0]  drop_o
);

  arb_state_e       state_q;
  logic             grant_q;
  logic             last_q;
  logic [TMO_W-1:0] cnt_q;
  logic [31:0]      s_addr_q, s_wdata_q, m0_rdata_q, m1_rdata_q;
  logic [3:0]       s_sel_q;
  logic             s_wen_q, s_ren_q;
  logic [1:0]       m_ack_q, m_err_q;

  logic [1:0]  valid, clr;
  hk_req_t     req0, req1, sel_req;
  logic        pick;
  logic        rsp_fire, rsp_err;
  logic [31:0] rsp_rdata;

  hk_arb_req_latch u_req0 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wen_i  (m0_wen),
    .ren_i  (m0_ren),
    .addr_i (m0_addr),
    .wdata_i(m0_wdata),
    .sel_i  (m0_sel),
    .clr_i  (clr[0]),
    .valid_o(valid[0]),
    .req_o  (req0),
    .drop_o (drop_o[0])
  );

  hk_arb_req_latch u_req1 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wen_i  (m1_wen),
    .ren_i  (m1_ren),
    .addr_i (m1_addr),
    .wdata_i(m1_wdata),
    .sel_i  (m1_sel),
    .clr_i  (clr[1]),
    .valid_o(valid[1]),
    .req_o  (req1),
    .drop_o (drop_o[1])
  );

  // Pending bits drop in the ack cycle of the granted master.
  assign clr[0] = (state_q == StDone) && !grant_q;
  assign clr[1] = (state_q == StDone) && grant_q;

  // Round-robin pick: a tie goes to the master not granted last.
  always_comb begin
    pick = valid[1];
    if (valid[0] && valid[1]) begin
      pick = ~last_q;
    end
  end
  assign sel_req = pick ? req1 : req0;

  // Response source: slave ack wins over a timeout hitting in the same cycle.
  always_comb begin
    rsp_fire  = (state_q == StWait) && (s_ack || (cnt_q == TMO));
    rsp_rdata = s_ack ? s_rdata : 32'h0;
    rsp_err   = s_ack ? s_err : 1'b1;
  end

  // Transaction FSM with registered slave and master outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_sel_q    <= '0;
      s_wen_q    <= 1'b0;
      s_ren_q    <= 1'b0;
      m_ack_q    <= '0;
      m_err_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      s_wen_q <= 1'b0;
      s_ren_q <= 1'b0;
      m_ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (|valid) begin
            grant_q   <= pick;
            s_addr_q  <= sel_req.addr;
            s_wdata_q <= sel_req.wdata;
            s_sel_q   <= sel_req.sel;
            s_wen_q   <= sel_req.wr;
            s_ren_q   <= ~sel_req.wr;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (rsp_fire) begin
            m_ack_q[grant_q] <= 1'b1;
            m_err_q[grant_q] <= rsp_err;
            if (grant_q) begin
              m1_rdata_q <= rsp_rdata;
            end else begin
              m0_rdata_q <= rsp_rdata;
            end
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + TMO_W'(1);
          end
        end
        StDone: begin
          last_q  <= grant_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_sel    = s_sel_q;
  assign s_wen    = s_wen_q;
  assign s_ren    = s_ren_q;
  assign m0_ack   = m_ack_q[0];
  assign m1_ack   = m_ack_q[1];
  assign m0_err   = m_err_q[0];
  assign m1_err   = m_err_q[1];
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_hk_bus_arbiter.sv
// Bench for hk_bus_arbiter: cycle table, directed corner sequences, randomized run vs. a model.
module tb_hk_bus_arbiter;

  localparam int unsigned Tmo = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ma[2], mwd[2], mrd[2];
  logic [3:0]  msel[2];
  logic        mwen[2], mren[2], mack[2], merr[2];
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic        s_wen, s_ren, s_ack, s_err;
  logic [1:0]  drop;

  int errs = 0;
  int checks = 0;

  hk_bus_arbiter #(.TMO_W(8), .TMO(8'(Tmo))) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m0_addr (ma[0]),
    .m0_wdata(mwd[0]),
    .m0_sel  (msel[0]),
    .m0_wen  (mwen[0]),
    .m0_ren  (mren[0]),
    .m0_rdata(mrd[0]),
    .m0_ack  (mack[0]),
    .m0_err  (merr[0]),
    .m1_addr (ma[1]),
    .m1_wdata(mwd[1]),
    .m1_sel  (msel[1]),
    .m1_wen  (mwen[1]),
    .m1_ren  (mren[1]),
    .m1_rdata(mrd[1]),
    .m1_ack  (mack[1]),
    .m1_err  (merr[1]),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_sel   (s_sel),
    .s_wen   (s_wen),
    .s_ren   (s_ren),
    .s_rdata (s_rdata),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .drop_o  (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Enter the next cycle: outputs of the new cycle are stable, inputs may be set for it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    for (int n = 0; n < 2; n++) begin
      mwen[n] = 1'b0;
      mren[n] = 1'b0;
      ma[n]   = 32'h0;
      mwd[n]  = 32'h0;
      msel[n] = 4'hF;
    end
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_rdata = 32'h0;
  endtask

  task automatic strobe(input int n, input logic wr, input logic [31:0] addr);
    mwen[n] = wr;
    mren[n] = ~wr;
    ma[n]   = addr;
    mwd[n]  = ~addr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    tick();
    rst = 1'b0;
  endtask

  task automatic quiet(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      tick();
      clr_in();
      chk(name, 32'({s_wen, s_ren, mack[0], mack[1]}), 32'h0);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  wen, ren;
    logic [31:0] a0, a1, d0, d1;
    logic        sack, serr;
    logic [31:0] srd;
    logic        swen, sren;
    logic [31:0] saddr, swd;
    logic [1:0]  mack, merr;
    logic [31:0] rd0, rd1;
  } vec_t;

  localparam logic [31:0] Z = 32'h0;
  vec_t tv[$];

  // Model state for the randomized run.
  logic [31:0] q_a[2], q_d[2], exp_rd[2], sch_rd;
  logic [3:0]  q_s[2];
  logic        q_w[2], q_pend[2];
  logic        m_last, m_busy, m_wait, sch_iss, sch_done, done_now, sch_err, ea;
  int          m_iss, m_gnt, sch_gnt;
  logic [1:0]  drop_exp;

  initial begin
    vec_t v;
    int   grants, acks, nstb, who, m0_acks, s_stbs, iss_c;
    logic prev_stb;
    clr_in();

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_s_strobes", 32'({s_wen, s_ren}), 32'h0);
    chk("rst_s_addr", s_addr, Z);
    chk("rst_acks", 32'({mack[0], mack[1]}), 32'h0);
    chk("rst_drop", 32'(drop), 32'h0);

    // ---------------- cycle table: single read, simultaneous writes, next tie ----------------
    //                rst  wen    ren    a0        a1        d0        d1    sack  serr  srd
    //                swen sren   saddr     swd       mack   merr   rd0            rd1
    tv.push_back('{1'b0, 2'b00, 2'b01, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, Z, Z, 2'b00, 2'b00, Z, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b1, Z, Z, 2'b00, 2'b00, Z, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b1, 1'b0, 32'h1,
                   1'b0, 1'b0, Z, Z, 2'b00, 2'b00, Z, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, Z, Z, 2'b01, 2'b00, 32'h1, Z});
    tv.push_back('{1'b1, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, Z, Z, 2'b00, 2'b00, 32'h1, Z});
    tv.push_back('{1'b0, 2'b11, 2'b00, 32'h30, 32'h18, 32'h55, 32'hAA, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, Z, Z, 2'b00, 2'b00, Z, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b1, 1'b0, 32'h30, 32'h55, 2'b00, 2'b00, Z, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b1, 1'b0, 32'h12345678,
                   1'b0, 1'b0, 32'h30, Z, 2'b00, 2'b00, Z, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, 32'h30, Z, 2'b01, 2'b00, 32'h12345678, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, 32'h30, Z, 2'b00, 2'b00, 32'h12345678, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b1, 1'b0, 32'h18, 32'hAA, 2'b00, 2'b00, 32'h12345678, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b1, 1'b0, Z,
                   1'b0, 1'b0, 32'h18, Z, 2'b00, 2'b00, 32'h12345678, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, 32'h18, Z, 2'b10, 2'b00, 32'h12345678, Z});
    tv.push_back('{1'b0, 2'b00, 2'b11, 32'h40, 32'h44, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, 32'h18, Z, 2'b00, 2'b00, 32'h12345678, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b1, 32'h40, Z, 2'b00, 2'b00, 32'h12345678, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b1, 1'b0, 32'h7,
                   1'b0, 1'b0, 32'h40, Z, 2'b00, 2'b00, 32'h12345678, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, 32'h40, Z, 2'b01, 2'b00, 32'h7, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, 32'h40, Z, 2'b00, 2'b00, 32'h7, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b1, 32'h44, Z, 2'b00, 2'b00, 32'h7, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b1, 1'b1, 32'h9,
                   1'b0, 1'b0, 32'h44, Z, 2'b00, 2'b00, 32'h7, Z});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, 32'h44, Z, 2'b10, 2'b10, 32'h7, 32'h9});
    tv.push_back('{1'b0, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z,
                   1'b0, 1'b0, 32'h44, Z, 2'b00, 2'b00, 32'h7, 32'h9});

    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      v = tv[i];
      chk($sformatf("tv%0d_s_wen", i), 32'(s_wen), 32'(v.swen));
      chk($sformatf("tv%0d_s_ren", i), 32'(s_ren), 32'(v.sren));
      chk($sformatf("tv%0d_s_addr", i), s_addr, v.saddr);
      if (v.swen) chk($sformatf("tv%0d_s_wdata", i), s_wdata, v.swd);
      chk($sformatf("tv%0d_m_ack", i), 32'({mack[1], mack[0]}), 32'(v.mack));
      if (v.mack[0]) chk($sformatf("tv%0d_m0_err", i), 32'(merr[0]), 32'(v.merr[0]));
      if (v.mack[1]) chk($sformatf("tv%0d_m1_err", i), 32'(merr[1]), 32'(v.merr[1]));
      chk($sformatf("tv%0d_m0_rdata", i), mrd[0], v.rd0);
      chk($sformatf("tv%0d_m1_rdata", i), mrd[1], v.rd1);
      chk($sformatf("tv%0d_drop", i), 32'(drop), 32'h0);
      rst     = v.rst;
      mwen[0] = v.wen[0];
      mwen[1] = v.wen[1];
      mren[0] = v.ren[0];
      mren[1] = v.ren[1];
      ma[0]   = v.a0;
      ma[1]   = v.a1;
      mwd[0]  = v.d0;
      mwd[1]  = v.d1;
      s_ack   = v.sack;
      s_err   = v.serr;
      s_rdata = v.srd;
      tick();
    end
    rst = 1'b0;
    clr_in();

    // ---------------- round-robin under load ----------------
    do_reset();
    strobe(0, 1'b0, 32'h100);
    strobe(1, 1'b0, 32'h200);
    nstb = 2;
    grants = 0;
    acks = 0;
    prev_stb = 1'b0;
    for (int c = 0; c < 200 && acks < 8; c++) begin
      tick();
      clr_in();
      s_ack = prev_stb;
      prev_stb = s_wen | s_ren;
      if (s_ren) begin
        who = (s_addr[9:8] == 2'd1) ? 0 : 1;
        chk($sformatf("rr_grant%0d", grants), 32'(who), 32'(grants % 2));
        grants++;
      end
      for (int n = 0; n < 2; n++) begin
        if (mack[n]) begin
          acks++;
          if (nstb < 8) begin
            strobe(n, 1'b0, (n == 0 ? 32'h100 : 32'h200) + 32'(nstb));
            nstb++;
          end
        end
      end
    end
    chk("rr_grants", 32'(grants), 32'd8);
    chk("rr_acks", 32'(acks), 32'd8);
    chk("rr_drop", 32'(drop), 32'h0);

    // ---------------- timeout ----------------
    do_reset();
    strobe(1, 1'b0, 32'h80);
    tick();
    clr_in();
    chk("to_pre_s_ren", 32'(s_ren), 32'h1);
    tick();
    s_ack = 1'b1;
    s_rdata = 32'hCAFE;
    tick();
    clr_in();
    chk("to_pre_ack", 32'(mack[1]), 32'h1);
    chk("to_pre_rdata", mrd[1], 32'hCAFE);
    tick();
    strobe(1, 1'b0, 32'h84);
    tick();
    clr_in();
    chk("to_s_ren", 32'(s_ren), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) begin
        chk($sformatf("to_noack%0d", k), 32'({mack[0], mack[1]}), 32'h0);
      end else begin
        chk("to_ack", 32'(mack[1]), 32'h1);
        chk("to_err", 32'(merr[1]), 32'h1);
        chk("to_rdata", mrd[1], Z);
        s_ack = 1'b1;
        s_rdata = 32'h5A5A;
      end
    end
    tick();
    s_ack = 1'b1;
    chk("to_done_once", 32'({mack[0], mack[1]}), 32'h0);
    quiet(4, "to_late_ack");

    // ---------------- drop ----------------
    do_reset();
    strobe(1, 1'b0, 32'h300);
    tick();
    clr_in();
    chk("dr_s_ren", 32'(s_ren), 32'h1);
    tick();
    strobe(0, 1'b0, 32'hA0);
    tick();
    strobe(0, 1'b0, 32'hB0);
    tick();
    clr_in();
    s_ack = 1'b1;
    s_rdata = 32'h1;
    chk("dr_flag", 32'(drop), 32'h1);
    m0_acks = 0;
    s_stbs = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      clr_in();
      if (s_ren | s_wen) begin
        s_stbs++;
        chk("dr_m0_addr", s_addr, 32'hA0);
      end
      s_ack = s_ren;
      if (mack[0]) m0_acks++;
    end
    chk("dr_m0_stbs", 32'(s_stbs), 32'h1);
    chk("dr_m0_acks", 32'(m0_acks), 32'h1);

    // ---------------- reset mid-WAIT ----------------
    do_reset();
    strobe(0, 1'b0, 32'h10);
    tick();
    clr_in();
    chk("rw_s_ren", 32'(s_ren), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_s_addr", s_addr, Z);
    chk("rw_strobes", 32'({s_wen, s_ren, mack[0], mack[1]}), 32'h0);
    chk("rw_rdata", mrd[0] | mrd[1], Z);
    s_ack = 1'b1;
    s_rdata = 32'h99;
    quiet(3, "rw_ignored_ack");
    strobe(1, 1'b0, 32'h20);
    tick();
    clr_in();
    chk("rw_m1_s_ren", 32'(s_ren), 32'h1);
    chk("rw_m1_s_addr", s_addr, 32'h20);
    tick();
    s_ack = 1'b1;
    s_rdata = 32'h77;
    tick();
    clr_in();
    chk("rw_m1_ack", 32'({mack[0], mack[1]}), 32'h1);
    chk("rw_m1_rdata", mrd[1], 32'h77);
    quiet(3, "rw_after");

    // ---------------- randomized run vs. transaction model ----------------
    do_reset();
    for (int n = 0; n < 2; n++) begin
      q_pend[n] = 1'b0;
      exp_rd[n] = 32'h0;
    end
    m_last = 1'b1;
    m_busy = 1'b0;
    m_wait = 1'b0;
    sch_iss = 1'b0;
    sch_done = 1'b0;
    drop_exp = 2'b00;
    m_iss = 0;
    m_gnt = 0;
    sch_gnt = 0;
    sch_rd = 32'h0;
    sch_err = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (sch_iss) begin
        iss_c = sch_gnt;
        chk("rnd_s_wen", 32'(s_wen), 32'(q_w[iss_c]));
        chk("rnd_s_ren", 32'(s_ren), 32'(!q_w[iss_c]));
        chk("rnd_s_addr", s_addr, q_a[iss_c]);
        chk("rnd_s_wdata", s_wdata, q_d[iss_c]);
        chk("rnd_s_sel", 32'(s_sel), 32'(q_s[iss_c]));
      end else begin
        chk("rnd_s_idle", 32'({s_wen, s_ren}), 32'h0);
      end
      for (int n = 0; n < 2; n++) begin
        ea = sch_done && (m_gnt == n);
        chk($sformatf("rnd_m%0d_ack", n), 32'(mack[n]), 32'(ea));
        if (ea) begin
          chk($sformatf("rnd_m%0d_err", n), 32'(merr[n]), 32'(sch_err));
          exp_rd[n] = sch_rd;
        end
        chk($sformatf("rnd_m%0d_rdata", n), mrd[n], exp_rd[n]);
      end
      chk("rnd_drop", 32'(drop), 32'(drop_exp));

      done_now = 1'b0;
      if (sch_iss) begin
        m_busy = 1'b1;
        m_wait = 1'b1;
        m_iss = c;
        m_gnt = sch_gnt;
        sch_iss = 1'b0;
      end
      if (sch_done) begin
        q_pend[m_gnt] = 1'b0;
        m_last = m_gnt[0];
        m_busy = 1'b0;
        sch_done = 1'b0;
        done_now = 1'b1;
      end

      for (int n = 0; n < 2; n++) begin
        int r;
        r = $urandom_range(0, 11);
        mwen[n] = (r == 0);
        mren[n] = (r == 1);
        ma[n]   = $urandom;
        mwd[n]  = $urandom;
        msel[n] = 4'($urandom);
      end
      s_ack   = ($urandom_range(0, 3) == 0);
      s_err   = ($urandom_range(0, 7) == 0);
      s_rdata = $urandom;

      // Slave responses only count in the wait window after the issue cycle.
      if (m_wait && c > m_iss) begin
        if (s_ack) begin
          sch_done = 1'b1;
          sch_rd = s_rdata;
          sch_err = s_err;
          m_wait = 1'b0;
        end else if (c == m_iss + int'(Tmo) + 1) begin
          sch_done = 1'b1;
          sch_rd = 32'h0;
          sch_err = 1'b1;
          m_wait = 1'b0;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (mwen[n] || mren[n]) begin
          if (q_pend[n]) begin
            drop_exp[n] = 1'b1;
          end else begin
            q_pend[n] = 1'b1;
            q_a[n] = ma[n];
            q_d[n] = mwd[n];
            q_s[n] = msel[n];
            q_w[n] = mwen[n];
          end
        end
      end
      if (!m_busy && !done_now && (q_pend[0] || q_pend[1])) begin
        sch_iss = 1'b1;
        if (q_pend[0] && q_pend[1]) sch_gnt = m_last ? 0 : 1;
        else sch_gnt = q_pend[1] ? 1 : 0;
      end
    end
    clr_in();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
